// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised video timing and test-pattern source.
// Free-running pixel counters (hcnt, vcnt) walk active/front-porch/sync/
// back-porch both horizontally and vertically; every output is registered
// one cycle after the counter state that produced it.
// Build option: define VTG_PATTERN_EN to include the four test patterns
// (colour bars, gradient, checker, solid). Without it the pattern logic is
// removed and the active region shows solid_rgb; timing is identical.
module video_timing_gen #(
  parameter int H_RES    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_RES    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12,
  parameter int CHK_LOG2 = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [23:0]   solid_rgb,
  output logic          hdmi_de,
  output logic          hdmi_hs,
  output logic          hdmi_vs,
  output logic [7:0]    hdmi_r,
  output logic [7:0]    hdmi_g,
  output logic [7:0]    hdmi_b,
  output logic          frame_start,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_RES);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_RES);
  localparam logic [CW-1:0] HS_BEGIN   = CW'(H_RES + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_RES + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEGIN   = CW'(V_RES + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_RES + V_FP + V_SYNC);

  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic          h_last;
  logic          v_last;
  logic          frame_first;
  logic          de_c;
  logic          hs_act;
  logic          vs_act;
  logic [23:0]   pat;

  assign h_last      = (hcnt == H_LAST);
  assign v_last      = (vcnt == V_LAST);
  assign frame_first = (hcnt == '0) && (vcnt == '0);

  // Position counters: hold at (0,0) while stopped so a re-enable starts a fresh frame.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      vcnt <= v_last ? '0 : vcnt + CW'(1);
    end else begin
      hcnt <= hcnt + CW'(1);
    end
  end

  // Region decode of the current counter position.
  always_comb begin
    de_c   = (hcnt < H_ACT_END) && (vcnt < V_ACT_END);
    hs_act = (hcnt >= HS_BEGIN) && (hcnt < HS_END);
    vs_act = (vcnt >= VS_BEGIN) && (vcnt < VS_END);
  end

`ifdef VTG_PATTERN_EN
  // Bars are tracked with a small pixel/bar counter pair instead of dividing
  // hcnt; the last bar never advances so it soaks up any H_RES remainder.
  localparam logic [CW-1:0] BAR_LAST = CW'(H_RES / 8 - 1);

  logic [1:0]    mode_q;
  logic [1:0]    mode_eff;
  logic [CW-1:0] bar_px;
  logic [2:0]    bar_idx;
  logic [7:0]    gx;
  logic [7:0]    gy;

  // The first pixel of a frame already uses the incoming mode; the rest of
  // the frame uses the copy captured on that pixel.
  assign mode_eff = frame_first ? mode : mode_q;
  assign gx       = 8'(hcnt);
  assign gy       = 8'(vcnt);

  // Latch the pattern select once per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 2'd0;
    end else if (en && frame_first) begin
      mode_q <= mode;
    end
  end

  // Bar position within the line, realigned at every line start.
  always_ff @(posedge clk) begin
    if (rst || !en || h_last) begin
      bar_px  <= '0;
      bar_idx <= 3'd0;
    end else if (bar_idx != 3'd7) begin
      if (bar_px == BAR_LAST) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px <= bar_px + CW'(1);
      end
    end
  end

  // Pattern colour for the current pixel.
  // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to
  // r = !idx[1], g = !idx[2], b = !idx[0].
  always_comb begin
    pat = 24'h000000;
    case (mode_eff)
      2'd0: pat = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
      2'd1: pat = {gx, gy, gx + gy};
      2'd2: pat = (hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2]) ? 24'hFFFFFF : 24'h000000;
      default: pat = solid_rgb;
    endcase
  end
`else
  logic unused_mode;
  assign unused_mode = ^mode;

  // Only a flat colour is available in this build.
  always_comb begin
    pat = solid_rgb;
  end
`endif

  // Output register stage; stopped or reset means blank, syncs inactive.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      hdmi_de     <= 1'b0;
      hdmi_hs     <= ~HS_POL;
      hdmi_vs     <= ~VS_POL;
      hdmi_r      <= 8'h00;
      hdmi_g      <= 8'h00;
      hdmi_b      <= 8'h00;
      frame_start <= 1'b0;
      x           <= '0;
      y           <= '0;
    end else begin
      hdmi_de     <= de_c;
      hdmi_hs     <= hs_act ? HS_POL : ~HS_POL;
      hdmi_vs     <= vs_act ? VS_POL : ~VS_POL;
      hdmi_r      <= de_c ? pat[23:16] : 8'h00;
      hdmi_g      <= de_c ? pat[15:8]  : 8'h00;
      hdmi_b      <= de_c ? pat[7:0]   : 8'h00;
      frame_start <= frame_first;
      x           <= hcnt;
      y           <= vcnt;
    end
  end

endmodule
